// File: rtl/frame_sched_rr.sv
// rtl/frame_sched_rr.sv - round-robin frame scheduler feeding a free-running serial frame checker
module frame_sched_rr #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 5,
    parameter int STAT_W    = 16,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int SLOT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*FRAME_LEN-1:0] req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       ser_out_o,
    output logic                       ser_first_o,
    output logic                       ser_last_o,
    input  logic                       chk_valid_i,
    output logic                       resp_valid_o,
    output logic [ID_W-1:0]            resp_id_o,
    output logic                       resp_ok_o,
    output logic [STAT_W-1:0]          stat_frames_o,
    output logic [STAT_W-1:0]          stat_ok_o
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
    localparam logic [ID_W-1:0]   PTR_RST   = ID_W'(N_REQ - 1);

    // Registered state
    logic [SLOT_W-1:0]    slot_q,        slot_d;
    logic [FRAME_LEN-1:0] shift_q,       shift_d;
    logic                 active_q,      active_d;
    logic [ID_W-1:0]      owner_q,       owner_d;
    logic [ID_W-1:0]      ptr_q,         ptr_d;
    logic                 resp_valid_q,  resp_valid_d;
    logic [ID_W-1:0]      resp_id_q,     resp_id_d;
    logic                 resp_ok_q,     resp_ok_d;
    logic [STAT_W-1:0]    stat_frames_q, stat_frames_d;
    logic [STAT_W-1:0]    stat_ok_q,     stat_ok_d;

    // Arbitration results
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      cand;
    int                   idx;
    logic                 ser_last;

    // Slot flags come straight from the registered slot so they line up with the checker counter
    assign ser_last      = (slot_q == LAST_SLOT);
    assign ser_first_o   = (slot_q == '0);
    assign ser_last_o    = ser_last;
    assign ser_out_o     = shift_q[0];
    assign resp_valid_o  = resp_valid_q;
    assign resp_id_o     = resp_id_q;
    assign resp_ok_o     = resp_ok_q;
    assign stat_frames_o = stat_frames_q;
    assign stat_ok_o     = stat_ok_q;

    // Round-robin search starting one past the last winner; grant is only visible in the last slot
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        idx         = 0;
        req_ready_o = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (ser_last && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Next-state: slot cadence, shifter load/shift, verdict capture and saturating statistics
    always_comb begin
        slot_d        = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        shift_d       = shift_q >> 1;
        active_d      = active_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        resp_valid_d  = 1'b0;
        resp_id_d     = resp_id_q;
        resp_ok_d     = resp_ok_q;
        stat_frames_d = stat_frames_q;
        stat_ok_d     = stat_ok_q;

        if (ser_last) begin
            // Verdict for the frame finishing now; idle frames report nothing
            if (active_q) begin
                resp_valid_d = 1'b1;
                resp_id_d    = owner_q;
                resp_ok_d    = chk_valid_i;
                if (stat_frames_q != '1) begin
                    stat_frames_d = stat_frames_q + 1'b1;
                end
                if (chk_valid_i && (stat_ok_q != '1)) begin
                    stat_ok_d = stat_ok_q + 1'b1;
                end
            end
            // Next frame loads in the same edge, so there is no bubble between frames
            if (grant_found) begin
                shift_d  = req_data_i[grant_idx*FRAME_LEN +: FRAME_LEN];
                owner_d  = grant_idx;
                ptr_d    = grant_idx;
                active_d = 1'b1;
            end else begin
                shift_d  = '0;
                active_d = 1'b0;
            end
        end
    end

    // State register with asynchronous reset shared with the checker's bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q        <= '0;
            shift_q       <= '0;
            active_q      <= 1'b0;
            owner_q       <= '0;
            ptr_q         <= PTR_RST;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_ok_q     <= 1'b0;
            stat_frames_q <= '0;
            stat_ok_q     <= '0;
        end else begin
            slot_q        <= slot_d;
            shift_q       <= shift_d;
            active_q      <= active_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_ok_q     <= resp_ok_d;
            stat_frames_q <= stat_frames_d;
            stat_ok_q     <= stat_ok_d;
        end
    end

endmodule

// File: tb/tb_frame_sched_rr.sv
// tb/tb_frame_sched_rr.sv - directed bench for frame_sched_rr with attached checker models
module tb_frame_sched_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance (STAT_W=16)
    logic [3:0]  req_valid = '0;
    logic [19:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        ser_out, ser_first, ser_last, chk_valid;
    logic        resp_valid, resp_ok;
    logic [1:0]  resp_id;
    logic [15:0] stat_frames, stat_ok;

    // Saturation instance (STAT_W=4)
    logic [3:0]  req_valid2 = '0;
    logic [19:0] req_data2  = '0;
    logic [3:0]  req_ready2;
    logic        ser_out2, ser_first2, ser_last2, chk_valid2;
    logic        resp_valid2, resp_ok2;
    logic [1:0]  resp_id2;
    logic [3:0]  stat_frames2, stat_ok2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    frame_sched_rr #(.N_REQ(4), .FRAME_LEN(5), .STAT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .ser_out_o(ser_out), .ser_first_o(ser_first), .ser_last_o(ser_last),
        .chk_valid_i(chk_valid),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_ok_o(resp_ok),
        .stat_frames_o(stat_frames), .stat_ok_o(stat_ok)
    );

    frame_sched_rr #(.N_REQ(4), .FRAME_LEN(5), .STAT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid2), .req_data_i(req_data2), .req_ready_o(req_ready2),
        .ser_out_o(ser_out2), .ser_first_o(ser_first2), .ser_last_o(ser_last2),
        .chk_valid_i(chk_valid2),
        .resp_valid_o(resp_valid2), .resp_id_o(resp_id2), .resp_ok_o(resp_ok2),
        .stat_frames_o(stat_frames2), .stat_ok_o(stat_ok2)
    );

    // Checker model: free-running 5-bit frame counter, flags frames with exactly two ones
    logic [2:0] cb1, ones1, cb2, ones2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cb1 <= '0; ones1 <= '0;
        end else if (cb1 == 3'd4) begin
            cb1 <= '0; ones1 <= '0;
        end else begin
            cb1 <= cb1 + 3'd1; ones1 <= ones1 + {2'b0, ser_out};
        end
    end
    assign chk_valid = (cb1 == 3'd4) && ((ones1 + {2'b0, ser_out}) == 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cb2 <= '0; ones2 <= '0;
        end else if (cb2 == 3'd4) begin
            cb2 <= '0; ones2 <= '0;
        end else begin
            cb2 <= cb2 + 3'd1; ones2 <= ones2 + {2'b0, ser_out2};
        end
    end
    assign chk_valid2 = (cb2 == 3'd4) && ((ones2 + {2'b0, ser_out2}) == 3'd2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    logic [4:0] bits;
    logic [3:0] exp_rdy;
    logic [3:0] alt_grant;

    initial begin
        // Reset state and idle operation
        do_reset();
        chk("rst_first", ser_first, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_ok", resp_ok, 0);
        chk("rst_stat_ok", stat_ok, 0);
        for (int c = 0; c < 15; c++) begin
            chk("idle_ser_out", ser_out, 0);
            chk("idle_ser_last", ser_last, (c % 5 == 4) ? 1 : 0);
            chk("idle_resp_valid", resp_valid, 0);
            adv();
        end
        chk("idle_stat_frames", stat_frames, 0);

        // Single frame 01001 from requester 0
        do_reset();
        req_valid = 4'b0001;
        req_data  = 20'b01001;
        bits      = 5'b01001;
        for (int c = 0; c < 4; c++) begin
            chk("single_ready_early", req_ready, 0);
            adv();
        end
        chk("single_ready", req_ready, 4'b0001);
        adv();
        req_valid = 4'b0000;
        chk("single_first", ser_first, 1);
        for (int c = 5; c < 10; c++) begin
            chk("single_ser_out", ser_out, bits[c-5]);
            adv();
        end
        chk("single_resp_valid", resp_valid, 1);
        chk("single_resp_id", resp_id, 0);
        chk("single_resp_ok", resp_ok, 1);
        chk("single_stat_frames", stat_frames, 1);
        chk("single_stat_ok", stat_ok, 1);
        adv();
        chk("single_resp_drop", resp_valid, 0);
        chk("single_ok_hold", resp_ok, 1);

        // Reset in slot 2 of a requester-2 frame (data 10110 -> 0,1,1,0,1)
        req_valid = 4'b0100;
        req_data  = 20'b10110 << 10;
        goto(14);
        chk("midrst_grant", req_ready, 4'b0100);
        adv();
        req_valid = 4'b0000;
        goto(17);
        chk("midrst_bit2", ser_out, 1);
        rst = 1'b1;
        #1;
        chk("midrst_ser_out", ser_out, 0);
        chk("midrst_first", ser_first, 1);
        chk("midrst_last", ser_last, 0);
        chk("midrst_ok", resp_ok, 0);
        chk("midrst_stat", stat_frames, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 10; c++) begin
            chk("midrst_no_resp", resp_valid, 0);
            chk("midrst_slot", ser_first, (c % 5 == 0) ? 1 : 0);
            adv();
        end

        // All four requesters held valid with 00111 (three ones -> never ok)
        do_reset();
        req_valid = 4'b1111;
        req_data  = {4{5'b00111}};
        for (int f = 0; f <= 5; f++) begin
            if (f < 5) begin
                goto(4 + 5 * f);
                exp_rdy = 4'b0001 << (f % 4);
                chk("rr_grant", req_ready, exp_rdy);
            end
            if (f >= 1) begin
                goto(10 + 5 * (f - 1));
                chk("rr_resp_valid", resp_valid, 1);
                chk("rr_resp_id", resp_id, (f - 1) % 4);
                chk("rr_resp_ok", resp_ok, 0);
            end
        end
        chk("rr_stat_frames", stat_frames, 5);
        chk("rr_stat_ok", stat_ok, 0);

        // Requesters 1 and 3 only: grants alternate 1,3,1,3
        do_reset();
        req_valid = 4'b1010;
        alt_grant = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            exp_rdy = (c % 5 == 4) ? alt_grant : 4'b0000;
            chk("alt_ready", req_ready, exp_rdy);
            if (c % 5 == 4) alt_grant = (alt_grant == 4'b0010) ? 4'b1000 : 4'b0010;
            adv();
        end
        req_valid = 4'b0000;

        // Saturation of 4-bit statistics with frames of 10001
        do_reset();
        req_valid2 = 4'b0001;
        req_data2  = 20'b10001;
        goto(75);
        chk("sat_frames_14", stat_frames2, 14);
        chk("sat_ok_14", stat_ok2, 14);
        goto(80);
        chk("sat_frames_15", stat_frames2, 15);
        chk("sat_ok_15", stat_ok2, 15);
        goto(105);
        chk("sat_resp_valid", resp_valid2, 1);
        chk("sat_resp_ok", resp_ok2, 1);
        chk("sat_frames_hold", stat_frames2, 15);
        chk("sat_ok_hold", stat_ok2, 15);
        req_valid2 = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
